// File: rtl/layer_compositor.sv
// N-layer priority compositor: colour-key transparency, frame-synchronous priority remap,
// per-frame collision reporting and RGB332 -> RGB888 expansion over a 2-stage pipeline.
module layer_compositor #(
   parameter int NUM_LAYERS = 4,
   parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic                        pixelValid,
   input  logic                        startOfFrame,
   input  logic [NUM_LAYERS-1:0]       drawReq,
   input  logic [8*NUM_LAYERS-1:0]     layerRGB,
   input  logic [7:0]                  backGroundRGB,
   input  logic [NUM_LAYERS-1:0]       layerEnable,
   input  logic                        keyEnable,
   input  logic [7:0]                  transparentKey,
   input  logic                        prioLoad,
   input  logic [IDX_W*NUM_LAYERS-1:0] prioMap,
   output logic                        prioPending,
   output logic [7:0]                  redOut,
   output logic [7:0]                  greenOut,
   output logic [7:0]                  blueOut,
   output logic [IDX_W:0]              layerSel,
   output logic                        pixelValidOut,
   output logic [NUM_LAYERS-1:0]       frameCollision,
   output logic                        collisionPulse
);
   localparam int MAP_W = IDX_W * NUM_LAYERS;
   localparam logic [IDX_W:0] SEL_BG = (IDX_W+1)'(NUM_LAYERS);

   function automatic logic [MAP_W-1:0] identity_map();
      logic [MAP_W-1:0] m;
      m = '0;
      for (int k = 0; k < NUM_LAYERS; k++) m[IDX_W*k +: IDX_W] = IDX_W'(k);
      return m;
   endfunction

   function automatic logic [7:0] expand3(input logic [2:0] f);
      return {f, {5{f[0]}}};
   endfunction

   function automatic logic [7:0] expand2(input logic [1:0] f);
      return {f, {6{f[0]}}};
   endfunction

   localparam logic [MAP_W-1:0] ID_MAP = identity_map();

   logic [MAP_W-1:0]        r_actMap, r_shdMap;
   logic                    r_prioPending;
   logic [NUM_LAYERS-1:0]   r_acc, r_frameColl;
   logic                    r_collPulse;

   logic [NUM_LAYERS-1:0]   w_qual, w_coll, w_others;
   logic [MAP_W-1:0]        w_mapUse;

   logic [NUM_LAYERS-1:0]   r_qual_p1;
   logic [8*NUM_LAYERS-1:0] r_rgb_p1;
   logic [7:0]              r_bg_p1;
   logic                    r_vld_p1;
   logic [MAP_W-1:0]        r_map_p1;

   logic                    w_found;
   logic [IDX_W-1:0]        w_slotIdx, w_winIdx;
   logic [7:0]              w_rgbNext;
   logic [IDX_W:0]          w_selNext;

   logic [7:0]              r_rgb_p2;
   logic [IDX_W:0]          r_sel_p2;
   logic                    r_vld_p2;

   always_comb begin
      w_qual   = '0;
      w_coll   = '0;
      w_others = '0;
      for (int i = 0; i < NUM_LAYERS; i++)
         w_qual[i] = drawReq[i] & layerEnable[i] & pixelValid &
                     ~(keyEnable & (layerRGB[8*i +: 8] == transparentKey));
      for (int i = 0; i < NUM_LAYERS; i++) begin
         w_others    = w_qual;
         w_others[i] = 1'b0;
         w_coll[i]   = w_qual[i] & (|w_others);
      end
   end

   // The startOfFrame pixel already uses the map that becomes active on this edge
   assign w_mapUse = (startOfFrame && r_prioPending) ? r_shdMap : r_actMap;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_actMap      <= ID_MAP;
         r_shdMap      <= ID_MAP;
         r_prioPending <= 1'b0;
         r_acc         <= '0;
         r_frameColl   <= '0;
         r_collPulse   <= 1'b0;
      end else begin
         if (startOfFrame && r_prioPending) r_actMap <= r_shdMap;
         if (prioLoad) r_shdMap <= prioMap;
         if (prioLoad) r_prioPending <= 1'b1;
         else if (startOfFrame) r_prioPending <= 1'b0;
         if (startOfFrame) begin
            r_frameColl <= r_acc;
            r_acc       <= w_coll;
         end else begin
            r_acc       <= r_acc | w_coll;
         end
         r_collPulse <= (|w_coll) & (startOfFrame | ~(|r_acc));
      end
   end

   // Stage 1: qualified vector, colours, valid and map for this pixel
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_qual_p1 <= '0;
         r_rgb_p1  <= '0;
         r_bg_p1   <= '0;
         r_vld_p1  <= 1'b0;
         r_map_p1  <= '0;
      end else begin
         r_qual_p1 <= w_qual;
         r_rgb_p1  <= layerRGB;
         r_bg_p1   <= backGroundRGB;
         r_vld_p1  <= pixelValid;
         r_map_p1  <= w_mapUse;
      end
   end

   always_comb begin
      w_found   = 1'b0;
      w_winIdx  = '0;
      w_slotIdx = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         w_slotIdx = r_map_p1[IDX_W*k +: IDX_W];
         if (!w_found && ({1'b0, w_slotIdx} < SEL_BG) && r_qual_p1[w_slotIdx]) begin
            w_found  = 1'b1;
            w_winIdx = w_slotIdx;
         end
      end
      w_selNext = w_found ? {1'b0, w_winIdx} : SEL_BG;
      w_rgbNext = w_found ? r_rgb_p1[{w_winIdx, 3'b000} +: 8] : (r_vld_p1 ? r_bg_p1 : 8'h00);
   end

   // Stage 2: winning colour, layer index and delayed valid
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_rgb_p2 <= '0;
         r_sel_p2 <= '0;
         r_vld_p2 <= 1'b0;
      end else begin
         r_rgb_p2 <= w_rgbNext;
         r_sel_p2 <= w_selNext;
         r_vld_p2 <= r_vld_p1;
      end
   end

   assign redOut         = expand3(r_rgb_p2[7:5]);
   assign greenOut       = expand3(r_rgb_p2[4:2]);
   assign blueOut        = expand2(r_rgb_p2[1:0]);
   assign layerSel       = r_sel_p2;
   assign pixelValidOut  = r_vld_p2;
   assign prioPending    = r_prioPending;
   assign frameCollision = r_frameColl;
   assign collisionPulse = r_collPulse;
endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: a per-pixel reference model queues expected results,
// an independent monitor compares them when they fall due.
module tb_layer_compositor;
   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            resetN = 1'b0;
   logic            pv, sof, ke, load;
   logic [N-1:0]    dr, en;
   logic [8*N-1:0]  rgb;
   logic [7:0]      bg, key;
   logic [IW*N-1:0] pmap;

   logic            prioPending, pixelValidOut, collisionPulse;
   logic [7:0]      redOut, greenOut, blueOut;
   logic [IW:0]     layerSel;
   logic [N-1:0]    frameCollision;

   layer_compositor #(.NUM_LAYERS(N)) dut (
      .clk(clk), .resetN(resetN), .pixelValid(pv), .startOfFrame(sof),
      .drawReq(dr), .layerRGB(rgb), .backGroundRGB(bg), .layerEnable(en),
      .keyEnable(ke), .transparentKey(key), .prioLoad(load), .prioMap(pmap),
      .prioPending(prioPending), .redOut(redOut), .greenOut(greenOut), .blueOut(blueOut),
      .layerSel(layerSel), .pixelValidOut(pixelValidOut),
      .frameCollision(frameCollision), .collisionPulse(collisionPulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int due; logic [7:0] r, g, b; logic [IW:0] sel; logic vld; } pix_t;
   typedef struct { int due; logic pulse; logic [N-1:0] fc; logic pend; } ctl_t;
   pix_t qp[$];
   ctl_t qc[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model state
   int         act_map[N], shd_map[N];
   bit         pend, seen;
   logic [N-1:0] acc, fc;

   function automatic logic [7:0] rep(input int v, input int bits);
      int lo;
      lo = 8 - bits;
      return 8'((v << lo) | (((v & 1) != 0) ? ((1 << lo) - 1) : 0));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin act_map[k] = k; shd_map[k] = k; end
      pend = 0; seen = 0; acc = '0; fc = '0;
      qp.delete(); qc.delete();
   endtask

   // Evaluate the current inputs, queue expectations, advance one clock
   task automatic cycle();
      bit q[N];
      int cnt, win;
      int use_map[N];
      logic [N-1:0] coll;
      logic [7:0] c;
      pix_t p;
      ctl_t t;
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         q[i] = dr[i] && en[i] && pv && !(ke && (rgb[8*i +: 8] == key));
         if (q[i]) cnt++;
      end
      for (int k = 0; k < N; k++) use_map[k] = (sof && pend) ? shd_map[k] : act_map[k];
      if (sof && pend) begin
         for (int k = 0; k < N; k++) act_map[k] = shd_map[k];
         pend = 0;
      end
      if (load) begin
         for (int k = 0; k < N; k++) shd_map[k] = int'(pmap[IW*k +: IW]);
         pend = 1;
      end
      win = N;
      for (int k = 0; k < N; k++) if (win == N && q[use_map[k]]) win = use_map[k];
      c = (win < N) ? rgb[8*win +: 8] : (pv ? bg : 8'h00);
      p.due = cyc + 2;
      p.r = rep(int'(c[7:5]), 3); p.g = rep(int'(c[4:2]), 3); p.b = rep(int'(c[1:0]), 2);
      p.sel = (IW+1)'(win); p.vld = pv;
      for (int i = 0; i < N; i++) coll[i] = q[i] && (cnt >= 2);
      t.pulse = (coll != 0) && (sof || !seen);
      seen = sof ? (coll != 0) : (seen || (coll != 0));
      if (sof) begin fc = acc; acc = coll; end
      else acc = acc | coll;
      t.due = cyc + 1; t.fc = fc; t.pend = pend;
      qp.push_back(p);
      qc.push_back(t);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin : monitor
      pix_t p;
      ctl_t t;
      if (resetN) begin
         while (qc.size() > 0 && qc[0].due <= cyc) begin
            t = qc.pop_front();
            if (t.due < cyc) chk("ctl_missed", 32'(t.due), 32'(cyc));
            else begin
               chk("collisionPulse", 32'(collisionPulse), 32'(t.pulse));
               chk("frameCollision", 32'(frameCollision), 32'(t.fc));
               chk("prioPending", 32'(prioPending), 32'(t.pend));
            end
         end
         while (qp.size() > 0 && qp[0].due <= cyc) begin
            p = qp.pop_front();
            if (p.due < cyc) chk("pix_missed", 32'(p.due), 32'(cyc));
            else begin
               chk("redOut", 32'(redOut), 32'(p.r));
               chk("greenOut", 32'(greenOut), 32'(p.g));
               chk("blueOut", 32'(blueOut), 32'(p.b));
               chk("layerSel", 32'(layerSel), 32'(p.sel));
               chk("pixelValidOut", 32'(pixelValidOut), 32'(p.vld));
            end
         end
      end
   end

   initial begin
      int pos;
      pv = 0; sof = 0; dr = '0; en = 4'hF; rgb = '0; bg = 8'h25;
      ke = 0; key = 8'h00; load = 0; pmap = 8'hE4;
      model_reset();
      #3;
      chk("rst_layerSel", 32'(layerSel), 32'd0);
      chk("rst_red", 32'(redOut), 32'd0);
      chk("rst_vldOut", 32'(pixelValidOut), 32'd0);
      chk("rst_pending", 32'(prioPending), 32'd0);
      chk("rst_frameColl", 32'(frameCollision), 32'd0);
      chk("rst_pulse", 32'(collisionPulse), 32'd0);
      repeat (2) @(posedge clk);
      #1 resetN = 1;

      // Fixed priority, then colour key, then layer disable
      sof = 1; pv = 1; dr = 4'b0110; rgb = {8'h00, 8'hE0, 8'h1C, 8'h00};
      cycle(); sof = 0;
      ke = 1; key = 8'h1C; cycle();
      en = 4'b1011; cycle();
      en = 4'hF; ke = 0;

      // Priority reprogram mid-frame, applied at startOfFrame
      dr = 4'b1001; rgb = {8'hE0, 8'h00, 8'h00, 8'h03};
      cycle();
      load = 1; pmap = 8'h1B; cycle(); load = 0;
      cycle(); cycle();
      sof = 1; cycle(); sof = 0;
      cycle();

      // Collision frame then clean frame
      dr = 4'b0000; repeat (3) cycle();
      dr = 4'b1001; cycle();
      dr = 4'b0000; repeat (3) cycle();
      sof = 1; cycle(); sof = 0;
      repeat (4) cycle();
      sof = 1; cycle(); sof = 0;

      // Invalid pixels with requests active
      pv = 0; dr = 4'hF; repeat (3) cycle(); pv = 1;

      // Reset mid-frame after a collision
      dr = 4'b0000; sof = 1; cycle(); sof = 0;
      dr = 4'b0001; rgb = {8'h1C, 8'h00, 8'h00, 8'hE0}; cycle();
      dr = 4'b1001; cycle();
      chk("pre_rst_pulse", 32'(collisionPulse), 32'd1);
      chk("pre_rst_red", 32'(redOut), 32'hFF);
      resetN = 0;
      #1;
      chk("async_rst_red", 32'(redOut), 32'd0);
      chk("async_rst_green", 32'(greenOut), 32'd0);
      chk("async_rst_sel", 32'(layerSel), 32'd0);
      chk("async_rst_vld", 32'(pixelValidOut), 32'd0);
      chk("async_rst_pulse", 32'(collisionPulse), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 resetN = 1;
      dr = 4'b0000; repeat (3) cycle();
      sof = 1; cycle(); sof = 0;
      cycle();

      // Randomised frames
      pos = 0;
      for (int n = 0; n < 1500; n++) begin
         sof = (pos == 0);
         pv  = ($urandom_range(0, 9) != 0);
         dr  = 4'($urandom_range(0, 15));
         for (int i = 0; i < N; i++)
            rgb[8*i +: 8] = ($urandom_range(0, 3) == 0) ? key : 8'($urandom_range(0, 255));
         bg = 8'($urandom_range(0, 255));
         if (sof) begin
            ke  = ($urandom_range(0, 1) == 1);
            key = ($urandom_range(0, 1) == 1) ? 8'h1C : 8'h00;
            en  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         end
         load = ($urandom_range(0, 29) == 0) || (sof && $urandom_range(0, 1) == 1);
         pmap = 8'($urandom_range(0, 255));
         cycle();
         pos = (pos == 36) ? 0 : pos + 1;
      end
      sof = 0; load = 0;

      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (qp.size() != 0 || qc.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d pixel and %0d control entries left, required 0", qp.size(), qc.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
